// File: rtl/clks_alot_p.sv
// Types and constants for the clock recovery/generation violation controller.
package clks_alot_p;

  localparam int VIOLATION_COUNT = 11;

  typedef enum logic [3:0] {
    VIOL_BP_HI_OVER       = 4'd0,
    VIOL_BP_HI_UNDER      = 4'd1,
    VIOL_BP_LO_OVER       = 4'd2,
    VIOL_BP_LO_UNDER      = 4'd3,
    VIOL_DRIFT_HI_POS     = 4'd4,
    VIOL_DRIFT_HI_NEG     = 4'd5,
    VIOL_DRIFT_LO_POS     = 4'd6,
    VIOL_DRIFT_LO_NEG     = 4'd7,
    VIOL_DRIFT_EXCESSIVE  = 4'd8,
    VIOL_DELTA_EXPECTED   = 4'd9,
    VIOL_DELTA_PREEMPTIVE = 4'd10
  } violation_e;

  typedef enum logic [1:0] {
    POLICY_IGNORE    = 2'b00,
    POLICY_WARNING   = 2'b01,
    POLICY_ERROR     = 2'b10,
    POLICY_ERROR_ALT = 2'b11
  } violation_policy_e;

  // Field order matches the write data layout: [3:2] post-lock, [1:0] pre-lock.
  typedef struct packed {
    violation_policy_e post_lock;
    violation_policy_e pre_lock;
  } violation_policy_s;

  localparam violation_policy_s VIOL_POLICY_RST = '{post_lock: POLICY_ERROR, pre_lock: POLICY_IGNORE};

  localparam logic [4:0] VIOL_ADDR_WARN     = 5'd0;
  localparam logic [4:0] VIOL_ADDR_ERR      = 5'd1;
  localparam logic [4:0] VIOL_ADDR_FIRST    = 5'd2;
  localparam logic [4:0] VIOL_ADDR_CNT_BASE = 5'd16;

  function automatic logic policy_is_error(input violation_policy_e p);
    return (p == POLICY_ERROR) || (p == POLICY_ERROR_ALT);
  endfunction

  function automatic logic policy_is_warning(input violation_policy_e p);
    return p == POLICY_WARNING;
  endfunction

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle type used by blocks that take a single clock/reset pair.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;

endpackage

// File: rtl/violation_slot.sv
// One violation: edge detect, policy register, sticky warn/err bits, optional saturating counter
// (CLKS_ALOT_VIOLATION_COUNTERS_EN). Status lands 1 cycle after the rising edge; no backpressure.
module violation_slot
  import clks_alot_p::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              arm_i,
  input  logic              locked_i,
  input  logic              viol_i,
  input  logic              cfg_we_i,
  input  violation_policy_s cfg_pol_i,
`ifdef CLKS_ALOT_VIOLATION_COUNTERS_EN
  input  logic              rd_clr_cnt_i,
`endif
  input  logic              rd_clr_warn_i,
  input  logic              rd_clr_err_i,
  output logic              err_event_o,
  output logic              warn_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic              viol_q;
  violation_policy_s pol_q, pol_d;
  logic              warn_q, warn_d;
  logic              err_q, err_d;
  violation_policy_e pol_act;
  logic              ev, ev_warn, ev_err;

  always_comb begin
    pol_act = locked_i ? pol_q.post_lock : pol_q.pre_lock;
    // A clear in the same cycle swallows the event entirely.
    ev      = arm_i & viol_i & ~viol_q & ~clear_i;
    ev_warn = ev & policy_is_warning(pol_act);
    ev_err  = ev & policy_is_error(pol_act);

    pol_d = cfg_we_i ? cfg_pol_i : pol_q;

    if (clear_i)            warn_d = 1'b0;
    else if (ev_warn)       warn_d = 1'b1;
    else if (rd_clr_warn_i) warn_d = 1'b0;
    else                    warn_d = warn_q;

    if (clear_i)           err_d = 1'b0;
    else if (ev_err)       err_d = 1'b1;
    else if (rd_clr_err_i) err_d = 1'b0;
    else                   err_d = err_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      viol_q <= 1'b0;
      pol_q  <= VIOL_POLICY_RST;
      warn_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      viol_q <= viol_i;
      pol_q  <= pol_d;
      warn_q <= warn_d;
      err_q  <= err_d;
    end
  end

  assign err_event_o = ev_err;
  assign warn_o      = warn_q;
  assign err_o       = err_q;

`ifdef CLKS_ALOT_VIOLATION_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  always_comb begin
    cnt_base = rd_clr_cnt_i ? '0 : cnt_q;
    if (clear_i)           cnt_d = '0;
    else if (ev)           cnt_d = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    else if (rd_clr_cnt_i) cnt_d = '0;
    else                   cnt_d = cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/violation_controller.sv
// Classifies violation edges into sticky warn/err status with IRQs, first-error capture and read-clear
// status port (counters via CLKS_ALOT_VIOLATION_COUNTERS_EN). Read data 1 cycle after rd_en_i; no backpressure.
module violation_controller
  import clks_alot_p::*;
#(
  parameter int CNT_W = 8
) (
  input  common_p::clk_dom_s          sys_dom_i,
  input  logic                        clear_state_i,
  input  logic                        locked_i,
  input  logic [VIOLATION_COUNT-1:0]  violations_i,
  input  logic                        cfg_wr_en_i,
  input  logic [3:0]                  cfg_addr_i,
  input  logic [3:0]                  cfg_wr_data_i,
  input  logic                        rd_en_i,
  input  logic [4:0]                  rd_addr_i,
  output logic [15:0]                 rd_data_o,
  output logic                        rd_valid_o,
  output logic                        warn_irq_o,
  output logic                        err_irq_o
);

  logic clk, rst;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  logic                       arm_q;
  logic [VIOLATION_COUNT-1:0] warn_st, err_st, err_ev;
  logic [CNT_W-1:0]           cnt [VIOLATION_COUNT];
  logic                       rd_clr_warn, rd_clr_err, rd_clr_first;
  logic                       fe_valid_q, fe_valid_d;
  logic [3:0]                 fe_id_q, fe_id_d;
  logic                       fe_hit;
  logic [3:0]                 fe_idx;
  logic [15:0]                rd_mux, rd_data_q, rd_data_d;
  logic                       rd_valid_q;

  assign rd_clr_warn  = rd_en_i && (rd_addr_i == VIOL_ADDR_WARN);
  assign rd_clr_err   = rd_en_i && (rd_addr_i == VIOL_ADDR_ERR);
  assign rd_clr_first = rd_en_i && (rd_addr_i == VIOL_ADDR_FIRST);

`ifdef CLKS_ALOT_VIOLATION_COUNTERS_EN
  logic [VIOLATION_COUNT-1:0] rd_clr_cnt;
`endif

  for (genvar i = 0; i < VIOLATION_COUNT; i++) begin : g_slot
`ifdef CLKS_ALOT_VIOLATION_COUNTERS_EN
    assign rd_clr_cnt[i] = rd_en_i && (rd_addr_i == VIOL_ADDR_CNT_BASE + 5'(i));
`endif
    violation_slot #(.CNT_W(CNT_W)) u_slot (
      .clk_i         (clk),
      .rst_i         (rst),
      .clear_i       (clear_state_i),
      .arm_i         (arm_q),
      .locked_i      (locked_i),
      .viol_i        (violations_i[i]),
      .cfg_we_i      (cfg_wr_en_i && (cfg_addr_i == 4'(i))),
      .cfg_pol_i     (violation_policy_s'(cfg_wr_data_i)),
`ifdef CLKS_ALOT_VIOLATION_COUNTERS_EN
      .rd_clr_cnt_i  (rd_clr_cnt[i]),
`endif
      .rd_clr_warn_i (rd_clr_warn),
      .rd_clr_err_i  (rd_clr_err),
      .err_event_o   (err_ev[i]),
      .warn_o        (warn_st[i]),
      .err_o         (err_st[i]),
      .cnt_o         (cnt[i])
    );
  end

  // Descending scan so the lowest simultaneous error index is the one left standing.
  always_comb begin
    fe_hit = 1'b0;
    fe_idx = '0;
    for (int i = VIOLATION_COUNT - 1; i >= 0; i--) begin
      if (err_ev[i]) begin
        fe_hit = 1'b1;
        fe_idx = 4'(i);
      end
    end
  end

  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_id_d    = fe_id_q;
    if (clear_state_i) begin
      fe_valid_d = 1'b0;
      fe_id_d    = '0;
    end else if (fe_hit && (!fe_valid_q || rd_clr_first)) begin
      fe_valid_d = 1'b1;
      fe_id_d    = fe_idx;
    end else if (rd_clr_first) begin
      fe_valid_d = 1'b0;
      fe_id_d    = '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr_i)
      VIOL_ADDR_WARN:  rd_mux = 16'(warn_st);
      VIOL_ADDR_ERR:   rd_mux = 16'(err_st);
      VIOL_ADDR_FIRST: rd_mux = {11'b0, fe_valid_q, fe_id_q};
      default: begin
        for (int i = 0; i < VIOLATION_COUNT; i++) begin
          if (rd_addr_i == VIOL_ADDR_CNT_BASE + 5'(i)) rd_mux = 16'(cnt[i]);
        end
      end
    endcase
    rd_data_d = rd_en_i ? rd_mux : '0;
  end

  // arm_q holds off edge detection until viol_q has captured the live inputs once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q      <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_id_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      arm_q      <= 1'b1;
      fe_valid_q <= fe_valid_d;
      fe_id_q    <= fe_id_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign warn_irq_o = |warn_st;
  assign err_irq_o  = |err_st;

endmodule

// File: tb/tb_violation_controller.sv
// Directed bench for violation_controller with a rule-level reference model checked every cycle.
module tb_violation_controller;

  localparam int NV      = 11;
  localparam int CNT_MAX = 255;
`ifdef CLKS_ALOT_VIOLATION_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_state = 1'b0;
  logic        locked = 1'b0;
  logic [10:0] viol = '0;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [3:0]  cfg_wr_data = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid, warn_irq, err_irq;
  common_p::clk_dom_s sys_dom;

  assign sys_dom = '{clk: clk, rst: rst};

  violation_controller #(.CNT_W(8)) dut (
    .sys_dom_i     (sys_dom),
    .clear_state_i (clear_state),
    .locked_i      (locked),
    .violations_i  (viol),
    .cfg_wr_en_i   (cfg_wr_en),
    .cfg_addr_i    (cfg_addr),
    .cfg_wr_data_i (cfg_wr_data),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .warn_irq_o    (warn_irq),
    .err_irq_o     (err_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: status as sets of flagged indices, policies as a table.
  bit [10:0]   m_warn, m_err, m_prev;
  bit          m_armed;
  bit          m_fe_valid;
  int          m_fe_id;
  int          m_cnt [NV];
  int          m_pre [NV];
  int          m_post[NV];
  bit          m_exp_valid;
  bit [15:0]   m_exp_data;

  function automatic bit [15:0] m_read(input int a);
    if (a == 0) return 16'(m_warn);
    if (a == 1) return 16'(m_err);
    if (a == 2) return m_fe_valid ? 16'(16 + m_fe_id) : 16'h0;
    if (CNT_EN && a >= 16 && a < 16 + NV) return 16'(m_cnt[a-16]);
    return 16'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_warn = '0; m_err = '0; m_prev = '0; m_armed = 0;
      m_fe_valid = 0; m_fe_id = 0; m_exp_valid = 0; m_exp_data = '0;
      for (int i = 0; i < NV; i++) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_post[i] = 2;
      end
    end else begin
      bit [10:0] ev;
      ev = m_armed ? (viol & ~m_prev) : '0;
      m_armed = 1;
      m_prev = viol;
      m_exp_valid = rd_en;
      m_exp_data = rd_en ? m_read(int'(rd_addr)) : 16'h0;
      if (clear_state) begin
        m_warn = '0; m_err = '0; m_fe_valid = 0; m_fe_id = 0;
        for (int i = 0; i < NV; i++) m_cnt[i] = 0;
      end else begin
        if (rd_en) begin
          if (rd_addr == 0) m_warn = '0;
          if (rd_addr == 1) m_err = '0;
          if (rd_addr == 2) begin m_fe_valid = 0; m_fe_id = 0; end
          if (rd_addr >= 16 && rd_addr < 16 + NV) m_cnt[rd_addr-16] = 0;
        end
        for (int i = 0; i < NV; i++) begin
          if (ev[i]) begin
            int p;
            p = locked ? m_post[i] : m_pre[i];
            if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            if (p == 1) m_warn[i] = 1;
            if (p >= 2) begin
              m_err[i] = 1;
              if (!m_fe_valid) begin m_fe_valid = 1; m_fe_id = i; end
            end
          end
        end
      end
      if (cfg_wr_en && cfg_addr < NV) begin
        m_pre[cfg_addr]  = int'(cfg_wr_data[1:0]);
        m_post[cfg_addr] = int'(cfg_wr_data[3:2]);
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_rd_valid", 32'(rd_valid), 32'(m_exp_valid));
    if (m_exp_valid) check("cyc_rd_data", 32'(rd_data), 32'(m_exp_data));
    check("cyc_warn_irq", 32'(warn_irq), 32'(m_warn != 0));
    check("cyc_err_irq", 32'(err_irq), 32'(m_err != 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [15:0] exp, input string name);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [3:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wr_data = d;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    check("reset_warn_irq", 32'(warn_irq), 32'd0);
    check("reset_err_irq", 32'(err_irq), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);

    // Pre-lock default policy ignores; post-lock default is error.
    viol[0] = 1; step(); viol[0] = 0; step();
    check("prelock_err_irq", 32'(err_irq), 32'd0);
    do_read(5'd1, 16'h0000, "prelock_err_st");
    locked = 1;
    step();
    viol[0] = 1; step();
    check("postlock_err_irq", 32'(err_irq), 32'd1);
    viol[0] = 0;
    do_read(5'd1, 16'h0001, "postlock_err_st");
    check("err_irq_after_rdclr", 32'(err_irq), 32'd0);
    do_read(5'd2, 16'h0010, "first_err_bit0");

    // Warning policy on index 9, level held for several cycles.
    cfg_write(4'd9, 4'b0100); step(); cfg_wr_en = 0;
    viol[9] = 1; repeat (5) step(); viol[9] = 0; step();
    check("warn9_irq", 32'(warn_irq), 32'd1);
    check("warn9_no_err", 32'(err_irq), 32'd0);
    do_read(5'd25, CNT_EN ? 16'h0001 : 16'h0000, "cnt9_one_event");
    do_read(5'd0, 16'h0200, "warn_st_bit9");
    check("warn_irq_after_rdclr", 32'(warn_irq), 32'd0);

    // Simultaneous errors: lowest index captured.
    viol[3] = 1; viol[7] = 1; step();
    check("err_3_7_irq", 32'(err_irq), 32'd1);
    viol[3] = 0; viol[7] = 0;
    do_read(5'd2, 16'h0013, "first_err_3_7");
    do_read(5'd2, 16'h0000, "first_err_cleared");
    do_read(5'd1, 16'h0088, "err_st_3_7");

    // Event racing a read-clear of an already-set bit.
    viol[5] = 1; step(); viol[5] = 0; step();
    viol[5] = 1;
    do_read(5'd1, 16'h0020, "race_read_old");
    check("race_err_irq", 32'(err_irq), 32'd1);
    viol[5] = 0;
    do_read(5'd1, 16'h0020, "race_bit_kept");
    check("race_err_irq_clr", 32'(err_irq), 32'd0);
    do_read(5'd2, 16'h0015, "first_err_bit5");

    // Clear beats a same-cycle event.
    viol[1] = 1; step(); viol[1] = 0; step();
    check("pre_clear_err_irq", 32'(err_irq), 32'd1);
    viol[4] = 1; clear_state = 1; step(); clear_state = 0;
    check("clear_err_irq", 32'(err_irq), 32'd0);
    repeat (2) step();
    check("clear_event_dropped", 32'(err_irq), 32'd0);
    viol[4] = 0;
    do_read(5'd1, 16'h0000, "clear_err_st");
    do_read(5'd2, 16'h0000, "clear_first_err");

    // Policy write takes effect only for events after the write edge.
    locked = 0;
    cfg_write(4'd6, 4'b0110); viol[6] = 1; step(); cfg_wr_en = 0;
    check("cfg_same_edge_old_policy", 32'(err_irq), 32'd0);
    viol[6] = 0; step(); viol[6] = 1; step(); viol[6] = 0;
    check("cfg_new_policy", 32'(err_irq), 32'd1);
    do_read(5'd3, 16'h0000, "reserved_addr");
    check("reserved_no_clear", 32'(err_irq), 32'd1);
    do_read(5'd1, 16'h0040, "err_st_bit6");

    // Counter saturation on ignored events.
    for (int k = 0; k < 300; k++) begin
      viol[2] = 1; step(); viol[2] = 0; step();
    end
    check("ignored_no_warn", 32'(warn_irq), 32'd0);
    check("ignored_no_err", 32'(err_irq), 32'd0);
    do_read(5'd18, CNT_EN ? 16'h00FF : 16'h0000, "cnt2_saturated");
    do_read(5'd18, 16'h0000, "cnt2_cleared");

    // Asynchronous reset with the violation held through release.
    locked = 1;
    viol[8] = 1; step();
    check("pre_rst_err_irq", 32'(err_irq), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_err_irq", 32'(err_irq), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("held_through_rst_no_event", 32'(err_irq), 32'd0);
    viol[8] = 0; step(); viol[8] = 1; step(); viol[8] = 0;
    check("post_rst_event", 32'(err_irq), 32'd1);
    do_read(5'd2, 16'h0018, "first_err_bit8");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
